// File: rtl/sub_32_4stage.sv
// sub_32_4stage: 4-stage pipelined subtractor with borrow chain and valid/ready flow control; define SUB_OVF_EN to add signed overflow
module sub_32_4stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SLICE = WIDTH / 4;
  logic [3:0]            v_q, v_d, br_q, br_d;
  logic [4:0]            rdy;
  logic [3:0][WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  // ready ripples back from the output; a stage can load if empty or if the next one can take its item
  always_comb begin
    rdy[4] = out_ready;
    for (int i = 3; i >= 0; i--) rdy[i] = !v_q[i] | rdy[i+1];
  end
  for (genvar k = 0; k < 4; k++) begin : g_st
    logic [WIDTH-1:0] ua, ub, ud, nd;
    logic             ubr, uv, l;
    logic [SLICE:0]   r;
    if (k == 0) begin : g_head
      assign ua  = a;
      assign ub  = b;
      assign ud  = '0;
      assign ubr = b_in;
      assign uv  = in_valid;
    end else begin : g_body
      assign ua  = a_q[k-1];
      assign ub  = b_q[k-1];
      assign ud  = d_q[k-1];
      assign ubr = br_q[k-1];
      assign uv  = v_q[k-1];
    end
    assign r = {1'b0, ua[k*SLICE +: SLICE]} - {1'b0, ub[k*SLICE +: SLICE]} - {{SLICE{1'b0}}, ubr};
    // resolve slice k; data only moves with a valid item so an idle stage keeps its contents
    always_comb begin
      l                    = rdy[k] & uv;
      nd                   = ud;
      nd[k*SLICE +: SLICE] = r[SLICE-1:0];
      v_d[k]               = rdy[k] ? uv : v_q[k];
      a_d[k]               = l ? ua : a_q[k];
      b_d[k]               = l ? ub : b_q[k];
      d_d[k]               = l ? nd : d_q[k];
      br_d[k]              = l ? r[SLICE] : br_q[k];
    end
    // stage register; reset empties the pipe and clears all data
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        d_q[k]  <= '0;
        br_q[k] <= 1'b0;
      end else begin
        v_q[k]  <= v_d[k];
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        d_q[k]  <= d_d[k];
        br_q[k] <= br_d[k];
      end
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = v_q[3];
  assign diff      = d_q[3];
  assign b_out     = br_q[3];
`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;
  logic sa, sb;
  assign sa = a_q[2][WIDTH-1];
  assign sb = b_q[2][WIDTH-1];
  // overflow when operand signs differ and the result sign departs from the minuend's
  always_comb ovf_d = g_st[3].l ? ((sa ^ sb) & (sa ^ g_st[3].r[SLICE-1])) : ovf_q;
  // overflow flag travels with the final stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sub_32_4stage.sv
// tb_sub_32_4stage: scoreboard bench for the pipelined subtractor
module tb_sub_32_4stage;
  logic        clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, b_in = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, b_out;
  logic [31:0] a = '0, b = '0, diff;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif
  typedef struct packed {logic [31:0] d; logic bo; logic ov;} exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0, last_pop = 0;
  bit   rnd_en = 1'b0;

  sub_32_4stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb, input logic xbi);
    exp_t   e;
    longint s;
    e.d  = xa - xb - {31'd0, xbi};
    e.bo = longint'(xa) < longint'(xb) + longint'(xbi);
    s    = longint'($signed(xa)) - longint'($signed(xb)) - longint'(xbi);
    e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    #2;
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got diff=%h with no pending operand", diff);
      end else begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("b_out", {31'd0, b_out}, {31'd0, e.bo});
`ifdef SUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
        last_pop = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xbi, input bit now);
    int n = 0;
    if (!now) tick();
    in_valid = 1'b1; a = xa; b = xb; b_in = xbi;
    #1;
    while (!in_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=0 expected 1 within %0d cycles", n);
      in_valid = 1'b0;
    end else begin
      q.push_back(model(xa, xb, xbi));
      @(posedge clock);
    end
  endtask

  task automatic lat(input logic [31:0] xa, input logic [31:0] xb, input logic xbi);
    exp_t e;
    e = model(xa, xb, xbi);
    send(xa, xb, xbi, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lat_edge_n", {31'd0, out_valid}, 32'd0);
    repeat (2) tick();
    #1;
    chk("lat_edge_n2", {31'd0, out_valid}, 32'd0);
    tick();
    #1;
    chk("lat_edge_n3", {31'd0, out_valid}, 32'd1);
    chk("lat_diff", diff, e.d);
    chk("lat_b_out", {31'd0, b_out}, {31'd0, e.bo});
`ifdef SUB_OVF_EN
    chk("lat_ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
  endtask

  task automatic drain();
    int n = 0;
    rnd_en = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] da [7] = '{32'd5, 32'd0, 32'h0100_0000, 32'd0, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] db [7] = '{32'd3, 32'd1, 32'd1, 32'd0, 32'h1234_5678, 32'd1, 32'hFFFF_FFFF};
    logic        dbi[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          c0;
    logic [31:0] xa;
    repeat (2) tick();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_b_out", {31'd0, b_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    lat(32'd5, 32'd3, 1'b0);
    chk("sub_5_3", diff, 32'h0000_0002);
    for (int i = 0; i < 7; i++) lat(da[i], db[i], dbi[i]);
    drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i) * 32'h1111_1111, 32'(i), 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    c0 = cyc;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'd5 * 32'h1111_1111, 32'd5, 1'b1, 1'b1);
    for (int i = 6; i <= 8; i++) send(32'(i) * 32'h1111_1111, 32'(i), 1'b1, 1'b0);
    idle(1);
    drain();
    chk("drain_one_per_cycle", 32'(last_pop - c0), 32'd7);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    idle(1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    idle(6);
    #1;
    chk("no_stale", {31'd0, out_valid}, 32'd0);
    lat($urandom, $urandom, 1'b1);
    drain();
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      xa = $urandom;
      send(xa, ($urandom_range(0, 7) == 0) ? xa : $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
